// File: rtl/ps2_rx_byte.sv
// PS/2 device-to-host receiver: synchronises and de-glitches PS2_CLK/PS2_DAT, deserialises
// 11-bit frames, checks odd parity and the stop bit, and holds the last good scan code.
`timescale 1ns / 1ps

module ps2_rx_byte #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       CLOCK_50,
    input  logic       KEY1,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);
    localparam int unsigned ToutW = ($clog2(TIMEOUT_CYCLES) > 16) ? $clog2(TIMEOUT_CYCLES) : 16;

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
    logic                   ps2_clk_s, ps2_dat_s;

    logic             filt_q, filt_d;
    logic [FiltW-1:0] fcnt_q, fcnt_d;
    logic             fall;

    state_e           state_q, state_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic [7:0]       scan_q, scan_d;
    logic             cv_q, cv_d, pe_q, pe_d, fe_q, fe_d;
    logic [ToutW-1:0] tcnt_q, tcnt_d;

    assign ps2_clk_s = clk_sync_q[SYNC_STAGES-1];
    assign ps2_dat_s = dat_sync_q[SYNC_STAGES-1];

    // Filtered clock only moves after FILTER_LEN consecutive differing samples.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        fall   = 1'b0;
        if (ps2_clk_s != filt_q) begin
            if (fcnt_q == FiltW'(FILTER_LEN - 1)) begin
                filt_d = ps2_clk_s;
                fall   = filt_q;
            end else begin
                fcnt_d = fcnt_q + FiltW'(1);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        par_d    = par_q;
        scan_d   = scan_q;
        cv_d     = 1'b0;
        pe_d     = 1'b0;
        fe_d     = 1'b0;
        tcnt_d   = tcnt_q;
        if (fall) begin
            tcnt_d = '0;
            case (state_q)
                StIdle: begin
                    if (!ps2_dat_s) begin
                        state_d  = StData;
                        bitcnt_d = '0;
                    end
                end
                StData: begin
                    shift_d  = {ps2_dat_s, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = StParity;
                end
                StParity: begin
                    par_d   = ps2_dat_s;
                    state_d = StStop;
                end
                StStop: begin
                    state_d = StIdle;
                    if (!ps2_dat_s) begin
                        fe_d = 1'b1;
                    end else if (^shift_q ^ par_q) begin
                        scan_d = shift_q;
                        cv_d   = 1'b1;
                    end else begin
                        pe_d = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end else if (state_q == StIdle) begin
            tcnt_d = '0;
        end else if (tcnt_q == ToutW'(TIMEOUT_CYCLES - 1)) begin
            // Device stopped clocking mid-frame: drop the partial byte.
            state_d = StIdle;
            fe_d    = 1'b1;
            tcnt_d  = '0;
        end else begin
            tcnt_d = tcnt_q + ToutW'(1);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!KEY1) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            filt_q     <= 1'b1;
            fcnt_q     <= '0;
            state_q    <= StIdle;
            bitcnt_q   <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            scan_q     <= '0;
            cv_q       <= 1'b0;
            pe_q       <= 1'b0;
            fe_q       <= 1'b0;
            tcnt_q     <= '0;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], PS2_CLK};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], PS2_DAT};
            filt_q     <= filt_d;
            fcnt_q     <= fcnt_d;
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            scan_q     <= scan_d;
            cv_q       <= cv_d;
            pe_q       <= pe_d;
            fe_q       <= fe_d;
            tcnt_q     <= tcnt_d;
        end
    end

    assign scan_code  = scan_q;
    assign code_valid = cv_q;
    assign parity_err = pe_q;
    assign frame_err  = fe_q;

endmodule

// File: tb/tb_ps2_rx_byte.sv
// Directed bench for ps2_rx_byte: good/bad frames, latency, timeout, glitches, mid-frame reset.
`timescale 1ns / 1ps

module tb_ps2_rx_byte;

    localparam int H = 20;  // PS/2 half period in CLOCK_50 cycles

    logic       CLOCK_50 = 1'b0;
    logic       KEY1     = 1'b0;
    logic       PS2_CLK  = 1'b1;
    logic       PS2_DAT  = 1'b1;
    logic [7:0] scan_code;
    logic       code_valid, parity_err, frame_err;

    int total = 0;
    int bad   = 0;
    int n_cv = 0, n_pe = 0, n_fe = 0, viol = 0, excl = 0;
    int cv0, pe0, fe0;
    int n;
    logic [7:0] prev_scan = 8'h00;

    ps2_rx_byte dut (
        .CLOCK_50  (CLOCK_50),
        .KEY1      (KEY1),
        .PS2_CLK   (PS2_CLK),
        .PS2_DAT   (PS2_DAT),
        .scan_code (scan_code),
        .code_valid(code_valid),
        .parity_err(parity_err),
        .frame_err (frame_err)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Flag-cycle counters plus invariants: scan_code moves only with code_valid, flags exclusive.
    always @(posedge CLOCK_50) begin
        #1;
        if (code_valid === 1'b1) n_cv++;
        if (parity_err === 1'b1) n_pe++;
        if (frame_err === 1'b1) n_fe++;
        if (KEY1 && code_valid !== 1'b1 && scan_code !== prev_scan) viol++;
        if (int'(code_valid) + int'(parity_err) + int'(frame_err) > 1) excl++;
        prev_scan = scan_code;
    end

    initial begin
        #(200_000 * 20);
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge CLOCK_50) PS2_DAT = b;
        repeat (H) @(negedge CLOCK_50);
        PS2_CLK = 1'b0;
        repeat (H) @(negedge CLOCK_50);
        PS2_CLK = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic stp);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(stp);
        repeat (20) @(negedge CLOCK_50);
    endtask

    task automatic glitch();
        repeat (15) @(negedge CLOCK_50);
        PS2_CLK = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        PS2_CLK = 1'b1;
        repeat (15) @(negedge CLOCK_50);
    endtask

    task automatic snap();
        cv0 = n_cv;
        pe0 = n_pe;
        fe0 = n_fe;
    endtask

    task automatic chk_flags(input string tag, input int ecv, input int epe, input int efe);
        chk({tag, "_cv"}, n_cv - cv0, ecv);
        chk({tag, "_pe"}, n_pe - pe0, epe);
        chk({tag, "_fe"}, n_fe - fe0, efe);
    endtask

    initial begin
        repeat (3) @(negedge CLOCK_50);
        chk("rst_scan", scan_code, 8'h00);
        chk("rst_cv", code_valid, 1'b0);
        chk("rst_pe", parity_err, 1'b0);
        chk("rst_fe", frame_err, 1'b0);
        KEY1 = 1'b1;
        repeat (5) @(negedge CLOCK_50);

        // Valid 0x1C with p=0, stop bit driven by hand to measure latency.
        snap();
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(((8'h1C >> i) & 8'h01) != 0);
        send_bit(1'b0);
        @(negedge CLOCK_50) PS2_DAT = 1'b1;
        repeat (H) @(negedge CLOCK_50);
        PS2_CLK = 1'b0;
        repeat (9) @(posedge CLOCK_50);
        #1 chk("lat_cv_early", code_valid, 1'b0);
        chk("lat_scan_early", scan_code, 8'h00);
        @(posedge CLOCK_50);
        #1 chk("lat_cv", code_valid, 1'b1);
        chk("lat_scan", scan_code, 8'h1C);
        @(posedge CLOCK_50);
        #1 chk("lat_cv_late", code_valid, 1'b0);
        repeat (H) @(negedge CLOCK_50);
        PS2_CLK = 1'b1;
        repeat (20) @(negedge CLOCK_50);
        chk_flags("v1c", 1, 0, 0);

        // Bad parity after reset: scan_code stays 0x00.
        @(negedge CLOCK_50) KEY1 = 1'b0;
        @(negedge CLOCK_50) KEY1 = 1'b1;
        chk("rst2_scan", scan_code, 8'h00);
        snap();
        send_frame(8'h1C, 1'b1, 1'b1);
        chk_flags("par", 0, 1, 0);
        chk("par_scan", scan_code, 8'h00);

        // Good parity, bad stop bit.
        snap();
        send_frame(8'h5A, 1'b1, 1'b0);
        chk_flags("stop", 0, 0, 1);
        chk("stop_scan", scan_code, 8'h00);

        // Timeout: start + 3 data bits, then the clock stays high.
        snap();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        @(negedge CLOCK_50) PS2_DAT = 1'b1;
        repeat (H) @(negedge CLOCK_50);
        PS2_CLK = 1'b0;
        n = 0;
        while (frame_err !== 1'b1 && n < 51000) begin
            @(posedge CLOCK_50);
            #1 n++;
            if (n == H) PS2_CLK = 1'b1;
        end
        chk("tout_latency", n, 50010);
        @(posedge CLOCK_50);
        #1 chk("tout_fe_drop", frame_err, 1'b0);
        repeat (5) @(negedge CLOCK_50);
        chk_flags("tout", 0, 0, 1);
        snap();
        send_frame(8'hF0, 1'b1, 1'b1);
        chk_flags("f0", 1, 0, 0);
        chk("f0_scan", scan_code, 8'hF0);

        // Short clock glitches in idle and between data bits.
        snap();
        glitch();
        glitch();
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            send_bit(((8'h1C >> i) & 8'h01) != 0);
            if (i == 3) glitch();
        end
        send_bit(1'b0);
        send_bit(1'b1);
        repeat (20) @(negedge CLOCK_50);
        chk_flags("glitch", 1, 0, 0);
        chk("glitch_scan", scan_code, 8'h1C);

        // One-cycle reset after 5 data bits.
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        @(negedge CLOCK_50) KEY1 = 1'b0;
        @(posedge CLOCK_50);
        #1 chk("mrst_scan", scan_code, 8'h00);
        chk("mrst_cv", code_valid, 1'b0);
        chk("mrst_pe", parity_err, 1'b0);
        chk("mrst_fe", frame_err, 1'b0);
        @(negedge CLOCK_50) KEY1 = 1'b1;
        repeat (5) @(negedge CLOCK_50);
        snap();
        send_frame(8'h5A, 1'b1, 1'b1);
        chk_flags("m5a", 1, 0, 0);
        chk("m5a_scan", scan_code, 8'h5A);

        chk("scan_only_on_valid", viol, 0);
        chk("flags_exclusive", excl, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
